spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI slave (CPOL=0) that runs entirely in the sysClk_i domain and oversamples the master's spiClk, ss_n and mosi through synchronizers.
- Shifts data MSb-first in both directions: receives a byte on MOSI while returning a host-supplied byte on MISO.
- Byte-streaming frames are supported: multiple bytes per ss_n assertion.
- Counterpart to the SPI master; used for loopback bring-up and as the device-side port of the SoC.

Parameters:
- DATA_WIDTH, 8: bits per SPI word.
- SYNC_STAGES, 2: flip-flop depth of the spiClk_i/ss_i_n/mosi_i synchronizers (min 2).
- IDLE_BYTE, 8'h00: word shifted out when no tx byte was loaded (underrun).

Ports:
- sysClk_i  input  1  system clock; must be >= 8x spiClk_i frequency.
- reset_i  input  1  synchronous, active-high reset on sysClk_i.
- spiClk_i  input  1  SPI clock from master (async).
- ss_i_n  input  1  slave select, active low (async).
- mosi_i  input  1  master-out data (async).
- miso_o  output  1  slave-out data.
- byte_to_send_i  input  DATA_WIDTH  next tx word.
- load_i  input  1  write byte_to_send_i into tx buffer; accepted only when tx_ready_o=1.
- tx_ready_o  output  1  tx buffer empty.
- byte_received_o  output  DATA_WIDTH  last completed rx word; held until the next word completes.
- rx_valid_o  output  1  one-cycle pulse when byte_received_o updates.
- tx_underrun_o  output  1  one-cycle pulse when IDLE_BYTE is substituted.
- busy_o  output  1  high while selected (state != Idle).

Behaviour:
- Reset values: miso_o=0, tx_ready_o=1, byte_received_o=0, rx_valid_o=0, tx_underrun_o=0, busy_o=0. Internally: bit counter=DATA_WIDTH-1, state=Idle, tx buffer empty.
- Synchronizers: each async input passes SYNC_STAGES flops. Edge detection compares the last sync stage with one extra registered copy: sclk_rise, sclk_fall, ss_fall, ss_rise.
- Tx buffer: single entry. load_i && tx_ready_o captures the byte and clears tx_ready_o. load_i while tx_ready_o=0 is ignored (buffer keeps the old byte). tx_ready_o sets the cycle after the buffer is copied into the shift register.
- States:
  - Idle: miso_o=0. On ss_fall, go to Load.
  - Load (1 cycle): tx shift reg <= buffer if full, else IDLE_BYTE with tx_underrun_o pulse. Buffer marked empty. miso_o <= MSb. bit counter=DATA_WIDTH-1. Go to Shift.
  - Shift:
    - sclk_rise: rx shift reg <= {rx[DATA_WIDTH-2:0], mosi_sync}.
    - sclk_fall: tx shift left and miso_o <= next bit.
    - On the sclk_rise where counter=0: go to Complete. Otherwise decrement the counter on each sclk_rise.
  - Complete (1 cycle): byte_received_o <= assembled word. rx_valid_o=1 in the following cycle. Go to Load if ss still low (next word), else Idle.
- Because the sclk_fall after the last bit occurs in the next word's Load context, Load has priority. The MSb of the new word is on miso_o before that sclk_fall is acted on, and that sclk_fall does not shift.
- Latency: rx_valid_o rises SYNC_STAGES+2 sysClk cycles after the raw 8th spiClk_i rising edge (±1 for synchronizer phase).
- ss_rise in any state except Complete: abort to Idle. The partial rx word is discarded (no rx_valid_o, byte_received_o unchanged). The tx buffer contents are preserved. miso_o=0 next cycle.
- ss_rise coincident with Complete: the word still completes, then go to Idle.
- sclk edges while ss is high are ignored.
- reset_i asserted mid-frame: all outputs return to reset values on the next sysClk_i edge. The tx buffer is emptied.
- Bit counter width is $clog2(DATA_WIDTH). The decrement never wraps in Shift (exits at 0).

Optional Feature:
- SPI_SLAVE_CPHA1_EN defined (mode 1):
  - Load does not drive the MSb; miso_o stays 0 until the first sclk_rise.
  - miso_o updates on sclk_rise; rx samples on sclk_fall.
  - The word completes on the 8th sclk_fall.
- Undefined: mode 0 as described above.

Test Plan:
- Reset, then load 8'hA5; master sends 8'h3C at sysClk/8 → miso sequence 1,0,1,0,0,1,0,1; byte_received_o=8'h3C with a single rx_valid_o pulse; tx_ready_o back to 1 after Load.
- No load before ss falls; master sends 8'hFF → miso carries 8'h00; tx_underrun_o pulses once; rx=8'hFF.
- Two-byte frame: load 8'h12, and after tx_ready_o rises load 8'h34; master sends 8'hC3,8'h5A with ss low throughout → miso 8'h12 then 8'h34; two rx_valid_o pulses with 8'hC3 then 8'h5A.
- ss_n deasserted after 4 bits of 8'hF0 → no rx_valid_o; byte_received_o keeps its previous value; busy_o=0; next full byte 8'h81 received correctly.
- load_i held while tx_ready_o=0 with 8'hEE after loading 8'h77 → 8'h77 transmitted, 8'hEE dropped.
- reset_i pulsed for 1 cycle mid-byte → all outputs at reset values the next cycle; subsequent clean byte 8'h69 received correctly.

Source files
------------

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// Purpose:
//   SPI slave for CPOL=0 that lives entirely in the sysClk_i domain. The
//   master's spiClk_i, ss_i_n and mosi_i are oversampled through
//   SYNC_STAGES-deep synchronizers and their edges are detected locally.
//   Data is shifted MSb-first in both directions: a word is received on MOSI
//   while a host-supplied word (or IDLE_BYTE on underrun) is returned on MISO.
//   Several words may be streamed while ss_i_n stays low.
//
// Build options:
//   SPI_SLAVE_CPHA1_EN  - when defined, SPI mode 1 (CPHA=1): MISO changes on
//                         the rising spiClk edge and MOSI is sampled on the
//                         falling edge. When undefined, SPI mode 0 (CPHA=0).
//
// Parameters:
//   DATA_WIDTH   bits per SPI word (>= 2)
//   SYNC_STAGES  synchronizer depth for spiClk_i/ss_i_n/mosi_i (>= 2)
//   IDLE_BYTE    word shifted out when no tx word was loaded
//
// Ports:
//   sysClk_i         in   system clock, at least 8x the spiClk_i rate
//   reset_i          in   synchronous active-high reset
//   spiClk_i         in   SPI clock from the master (asynchronous)
//   ss_i_n           in   slave select, active low (asynchronous)
//   mosi_i           in   master-out data (asynchronous)
//   miso_o           out  slave-out data
//   byte_to_send_i   in   next tx word
//   load_i           in   write byte_to_send_i into the tx buffer when ready
//   tx_ready_o       out  tx buffer empty
//   byte_received_o  out  last completed rx word
//   rx_valid_o       out  one-cycle pulse when byte_received_o updates
//   tx_underrun_o    out  one-cycle pulse when IDLE_BYTE is substituted
//   busy_o           out  high while a frame is in progress
// -----------------------------------------------------------------------------
module spi_slave #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_BYTE   = 8'h00
) (
  input  logic                  sysClk_i,
  input  logic                  reset_i,
  input  logic                  spiClk_i,
  input  logic                  ss_i_n,
  input  logic                  mosi_i,
  output logic                  miso_o,
  input  logic [DATA_WIDTH-1:0] byte_to_send_i,
  input  logic                  load_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] byte_received_o,
  output logic                  rx_valid_o,
  output logic                  tx_underrun_o,
  output logic                  busy_o
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_COMPLETE = 2'd3
  } state_t;

  // Synchronizer chains; index 0 is the stage nearest the pin.
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   ss_prev_q;

  logic sclk_s;
  logic ss_s;
  logic mosi_s;
  logic sclk_rise_s;
  logic sclk_fall_s;
  logic ss_fall_s;
  logic ss_rise_s;

  state_t                 state_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [DATA_WIDTH-1:0]  tx_buf_q;
  logic                   tx_ready_q;
  logic [DATA_WIDTH-1:0]  tx_shift_q;
  logic [DATA_WIDTH-1:0]  rx_shift_q;
  logic [DATA_WIDTH-1:0]  byte_received_q;
  logic                   rx_valid_q;
  logic                   tx_underrun_q;
  logic                   miso_q;

  logic [DATA_WIDTH-1:0]  tx_src_d;
  logic [DATA_WIDTH-1:0]  tx_shift_d;
  logic [DATA_WIDTH-1:0]  rx_shift_d;

  // Synchronize the asynchronous SPI pins and keep one extra copy for edges.
  always_ff @(posedge sysClk_i) begin
    if (reset_i) begin
      // ss resets high so that a released reset never fakes a select edge
      // unless the master really holds ss low.
      sclk_sync_q <= {SYNC_STAGES{1'b0}};
      ss_sync_q   <= {SYNC_STAGES{1'b1}};
      mosi_sync_q <= {SYNC_STAGES{1'b0}};
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spiClk_i};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_i_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s        = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_prev_q;
  assign sclk_fall_s = ~sclk_s & sclk_prev_q;
  assign ss_fall_s   = ~ss_s & ss_prev_q;
  assign ss_rise_s   = ss_s & ~ss_prev_q;

  // Next-state values for the shift registers and the word to transmit.
  always_comb begin
    tx_src_d = IDLE_BYTE;
    if (!tx_ready_q) begin
      tx_src_d = tx_buf_q;
    end else begin
      tx_src_d = IDLE_BYTE;
    end
    // Rotate rather than shift: the bit leaving the top is never observed
    // again, and rotating keeps every register bit in use.
    tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], tx_shift_q[DATA_WIDTH-1]};
    rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
  end

  // Frame FSM, shift registers, tx buffer and all registered outputs.
  always_ff @(posedge sysClk_i) begin
    if (reset_i) begin
      state_q         <= ST_IDLE;
      bit_cnt_q       <= CNT_MAX;
      tx_buf_q        <= {DATA_WIDTH{1'b0}};
      tx_ready_q      <= 1'b1;
      tx_shift_q      <= {DATA_WIDTH{1'b0}};
      rx_shift_q      <= {DATA_WIDTH{1'b0}};
      byte_received_q <= {DATA_WIDTH{1'b0}};
      rx_valid_q      <= 1'b0;
      tx_underrun_q   <= 1'b0;
      miso_q          <= 1'b0;
    end else begin
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          miso_q <= 1'b0;
          if (ss_fall_s) begin
            state_q <= ST_LOAD;
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_LOAD: begin
          if (ss_rise_s) begin
            // Abort: the tx buffer is left untouched.
            state_q <= ST_IDLE;
            miso_q  <= 1'b0;
          end else begin
            tx_shift_q <= tx_src_d;
            if (tx_ready_q) begin
              tx_underrun_q <= 1'b1;
            end else begin
              tx_underrun_q <= 1'b0;
            end
            tx_ready_q <= 1'b1;
`ifdef SPI_SLAVE_CPHA1_EN
            // Mode 1 drives the MSb on the first rising spiClk edge.
            miso_q <= 1'b0;
`else
            // Mode 0 must present the MSb before the first rising edge.
            miso_q <= tx_src_d[DATA_WIDTH-1];
`endif
            bit_cnt_q <= CNT_MAX;
            state_q   <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (ss_rise_s) begin
            // Abort: the partial rx word is dropped, nothing is reported.
            state_q <= ST_IDLE;
            miso_q  <= 1'b0;
`ifdef SPI_SLAVE_CPHA1_EN
          end else if (sclk_rise_s) begin
            miso_q     <= tx_shift_q[DATA_WIDTH-1];
            tx_shift_q <= tx_shift_d;
          end else if (sclk_fall_s) begin
            rx_shift_q <= rx_shift_d;
            if (bit_cnt_q == CNT_ZERO) begin
              state_q <= ST_COMPLETE;
            end else begin
              bit_cnt_q <= bit_cnt_q - CNT_ONE;
            end
`else
          end else if (sclk_rise_s) begin
            rx_shift_q <= rx_shift_d;
            if (bit_cnt_q == CNT_ZERO) begin
              state_q <= ST_COMPLETE;
            end else begin
              bit_cnt_q <= bit_cnt_q - CNT_ONE;
            end
          end else if (sclk_fall_s && (bit_cnt_q != CNT_MAX)) begin
            // A falling edge seen before any rising edge of this word is the
            // trailing edge of the previous word's last bit; it must not
            // disturb the MSb that Load already placed on MISO.
            tx_shift_q <= tx_shift_d;
            miso_q     <= tx_shift_d[DATA_WIDTH-1];
`endif
          end else begin
            state_q <= ST_SHIFT;
          end
        end

        ST_COMPLETE: begin
          // Completes even if ss rises in this very cycle.
          byte_received_q <= rx_shift_q;
          rx_valid_q      <= 1'b1;
          if (ss_s) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_LOAD;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          miso_q  <= 1'b0;
        end
      endcase

      // Host write into the single-entry buffer; a later assignment wins
      // over Load marking the buffer empty in the same cycle.
      if (load_i && tx_ready_q) begin
        tx_buf_q   <= byte_to_send_i;
        tx_ready_q <= 1'b0;
      end else begin
        tx_buf_q <= tx_buf_q;
      end
    end
  end

  assign miso_o          = miso_q;
  assign tx_ready_o      = tx_ready_q;
  assign byte_received_o = byte_received_q;
  assign rx_valid_o      = rx_valid_q;
  assign tx_underrun_o   = tx_underrun_q;
  assign busy_o          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
//
// Directed bench for spi_slave (default mode 0 build). A behavioural SPI
// master drives spiClk at sysClk/8 and collects MISO just before each rising
// edge. Inputs change 3 ns after a rising sysClk edge, well away from it.
// -----------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_spi_slave;

  logic       clk;
  logic       reset;
  logic       sclk;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic [7:0] tx_byte;
  logic       load;
  logic       tx_ready;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       underrun;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int rx_cnt = 0;
  int ur_cnt = 0;
  logic [7:0] rx_log [$];

  spi_slave #(
    .DATA_WIDTH (8),
    .SYNC_STAGES(2),
    .IDLE_BYTE  (8'h00)
  ) dut (
    .sysClk_i       (clk),
    .reset_i        (reset),
    .spiClk_i       (sclk),
    .ss_i_n         (ss_n),
    .mosi_i         (mosi),
    .miso_o         (miso),
    .byte_to_send_i (tx_byte),
    .load_i         (load),
    .tx_ready_o     (tx_ready),
    .byte_received_o(rx_byte),
    .rx_valid_o     (rx_valid),
    .tx_underrun_o  (underrun),
    .busy_o         (busy)
  );

  // Rising edges at 7 mod 10 ns, falling edges at 2 mod 10 ns.
  initial begin
    clk = 1'b0;
    #2;
    forever #5 clk = ~clk;
  end

  // Count output pulses on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rx_cnt = rx_cnt + 1;
      rx_log.push_back(rx_byte);
    end
    if (underrun === 1'b1) ur_cnt = ur_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ss_begin();
    ss_n = 1'b0;
    #80;
  endtask

  task automatic ss_end();
    #40;
    ss_n = 1'b1;
    #100;
  endtask

  // Master shifts nbits MSb-first; MISO is taken just before each rising edge.
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      #40;
      rx = {rx[6:0], miso};
      sclk = 1'b1;
      #40;
      sclk = 1'b0;
    end
  endtask

  // Host write into the tx buffer, bounded wait for tx_ready.
  task automatic load_byte(input logic [7:0] b, input string tag);
    for (int i = 0; i < 50 && tx_ready !== 1'b1; i++) #10;
    check(tag, {7'h00, tx_ready}, 8'h01);
    load    = 1'b1;
    tx_byte = b;
    #10;
    load = 1'b0;
  endtask

  initial begin : stim
    logic [7:0] got;
    int         rx0;
    int         ur0;

    reset   = 1'b1;
    sclk    = 1'b0;
    ss_n    = 1'b1;
    mosi    = 1'b0;
    load    = 1'b0;
    tx_byte = 8'h00;
    #30;
    check("rst_miso",     {7'h00, miso},     8'h00);
    check("rst_tx_ready", {7'h00, tx_ready}, 8'h01);
    check("rst_rx_byte",  rx_byte,           8'h00);
    check("rst_rx_valid", {7'h00, rx_valid}, 8'h00);
    check("rst_underrun", {7'h00, underrun}, 8'h00);
    check("rst_busy",     {7'h00, busy},     8'h00);
    reset = 1'b0;
    #20;

    // 1: single byte, A5 out / 3C in
    load_byte(8'hA5, "t1_load");
    check("t1_ready_pre", {7'h00, tx_ready}, 8'h00);
    rx0 = rx_cnt;
    ss_begin();
    check("t1_ready_after_load", {7'h00, tx_ready}, 8'h01);
    xfer(8'h3C, 8, got);
    ss_end();
    check("t1_miso", got, 8'hA5);
    check("t1_rx_byte", rx_byte, 8'h3C);
    check("t1_rx_pulses", 8'(rx_cnt - rx0), 8'h01);

    // 2: underrun, FF in
    ur0 = ur_cnt;
    ss_begin();
    xfer(8'hFF, 8, got);
    check("t2_underrun_pulses", 8'(ur_cnt - ur0), 8'h01);
    ss_end();
    check("t2_miso", got, 8'h00);
    check("t2_rx_byte", rx_byte, 8'hFF);

    // 3: two-byte stream
    load_byte(8'h12, "t3_load1");
    rx0 = rx_cnt;
    ss_begin();
    load_byte(8'h34, "t3_load2");
    xfer(8'hC3, 8, got);
    check("t3_miso1", got, 8'h12);
    xfer(8'h5A, 8, got);
    check("t3_miso2", got, 8'h34);
    ss_end();
    check("t3_rx_pulses", 8'(rx_cnt - rx0), 8'h02);
    if (rx_cnt - rx0 == 2) begin
      check("t3_rx_first",  rx_log[rx_log.size()-2], 8'hC3);
      check("t3_rx_second", rx_log[rx_log.size()-1], 8'h5A);
    end else begin
      check("t3_rx_log_size", 8'(rx_cnt - rx0), 8'h02);
    end

    // 4: abort after 4 bits, then a clean byte
    rx0 = rx_cnt;
    ss_begin();
    xfer(8'hF0, 4, got);
    ss_end();
    check("t4_abort_no_pulse", 8'(rx_cnt - rx0), 8'h00);
    check("t4_abort_rx_kept", rx_byte, 8'h5A);
    check("t4_abort_busy", {7'h00, busy}, 8'h00);
    ss_begin();
    xfer(8'h81, 8, got);
    ss_end();
    check("t4_rx_byte", rx_byte, 8'h81);
    check("t4_rx_pulses", 8'(rx_cnt - rx0), 8'h01);

    // 5: load while buffer full is ignored
    load_byte(8'h77, "t5_load");
    load    = 1'b1;
    tx_byte = 8'hEE;
    #30;
    load = 1'b0;
    check("t5_ready_full", {7'h00, tx_ready}, 8'h00);
    ss_begin();
    xfer(8'h00, 8, got);
    ss_end();
    check("t5_miso", got, 8'h77);

    // 6: reset mid-byte
    ss_begin();
    load_byte(8'h3A, "t6_load");
    xfer(8'hAA, 4, got);
    reset = 1'b1;
    #10;
    check("t6_rst_miso",     {7'h00, miso},     8'h00);
    check("t6_rst_tx_ready", {7'h00, tx_ready}, 8'h01);
    check("t6_rst_rx_byte",  rx_byte,           8'h00);
    check("t6_rst_rx_valid", {7'h00, rx_valid}, 8'h00);
    check("t6_rst_underrun", {7'h00, underrun}, 8'h00);
    check("t6_rst_busy",     {7'h00, busy},     8'h00);
    reset = 1'b0;
    ss_end();
    rx0 = rx_cnt;
    ss_begin();
    xfer(8'h69, 8, got);
    ss_end();
    check("t6_miso", got, 8'h00);
    check("t6_rx_byte", rx_byte, 8'h69);
    check("t6_rx_pulses", 8'(rx_cnt - rx0), 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
